// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI4-Lite response codes, FSM states and default widths
package axi_lite_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 64;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_e;

    typedef enum logic [2:0] {
        W_IDLE   = 3'd0,
        W_DATA   = 3'd1,
        W_ADDR   = 3'd2,
        W_COMMIT = 3'd3,
        W_RESP   = 3'd4
    } w_state_e;

endpackage

// File: rtl/axi_lite_sram_slave_if.sv
// rtl/axi_lite_sram_slave_if.sv - AXI4-Lite bus bundle with master/slave modports
interface axi_lite_sram_slave_if
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/sram_bank.sv
// rtl/sram_bank.sv - synchronous-read SRAM with one byte-masked write port
module sram_bank #(
    parameter int DEPTH  = 4096,
    parameter int DATA_W = 64,
    parameter int IDX_W  = 12
) (
    input  logic                clk,
    input  logic                rd_en,
    input  logic [IDX_W-1:0]    rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic [DATA_W/8-1:0] wr_strb,
    input  logic [DATA_W-1:0]   wr_data
);
    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Both ports update on the same edge, so a same-word read sees the old contents.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
        if (wr_en) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi_lite_sram_slave.sv
// rtl/axi_lite_sram_slave.sv - AXI4-Lite slave over a byte-maskable SRAM with configurable read latency
module axi_lite_sram_slave
    import axi_lite_pkg::*;
#(
    parameter int                ADDR_W = ADDR_W_DEF,
    parameter int                DATA_W = DATA_W_DEF,
    parameter int                DEPTH  = 4096,
    parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(32'h8000_0000),
    parameter int                RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_lite_sram_slave_if.slave  bus
);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH * 8);

    // Offset compare is one bit wider so BASE+DEPTH*8 may sit at the top of the address map.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a >= BASE) && ({1'b0, ADDR_W'(a - BASE)} < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(ADDR_W'(a - BASE) >> 3);
    endfunction

    r_state_e            r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic                r_ok;
    logic [1:0]          rresp_q;
    logic                rvalid_i;
    logic                ar_hs;
    logic                rd_sample;
    logic [IDX_W-1:0]    rd_addr;
    logic [DATA_W-1:0]   sram_q;

    w_state_e            w_state;
    logic [IDX_W-1:0]    w_idx;
    logic                w_ok;
    logic [DATA_W-1:0]   w_data;
    logic [STRB_W-1:0]   w_strb;
    logic [1:0]          bresp_q;
    logic                aw_hs;
    logic                w_hs;
    logic                sram_we;

    // Ready/valid outputs derive only from state and reset, never from the peer's valid.
    assign bus.arready = rst && (r_state == R_IDLE);
    assign rvalid_i    = rst && (r_state == R_RESP);
    assign bus.rvalid  = rvalid_i;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = (rvalid_i && r_ok) ? sram_q : '0;

    assign bus.awready = rst && ((w_state == W_IDLE) || (w_state == W_ADDR));
    assign bus.wready  = rst && ((w_state == W_IDLE) || (w_state == W_DATA));
    assign bus.bvalid  = rst && (w_state == W_RESP);
    assign bus.bresp   = bresp_q;

    assign ar_hs = bus.arvalid && bus.arready;
    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid  && bus.wready;

    // The SRAM is read on the edge that enters R_RESP; its output then holds until the next read.
    assign rd_sample = ((r_state == R_IDLE) && ar_hs && (RD_LAT == 1)) ||
                       ((r_state == R_WAIT) && (r_cnt == CNT_W'(1)));
    assign rd_addr   = (r_state == R_IDLE) ? addr_idx(bus.araddr) : r_idx;
    assign sram_we   = rst && (w_state == W_COMMIT) && w_ok;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_ok    <= 1'b0;
            rresp_q <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_idx <= addr_idx(bus.araddr);
                        r_ok  <= addr_ok(bus.araddr);
                        r_cnt <= CNT_W'(RD_LAT - 1);
                        if (RD_LAT == 1) begin
                            rresp_q <= addr_ok(bus.araddr) ? RESP_OKAY : RESP_DECERR;
                            r_state <= R_RESP;
                        end else begin
                            r_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        rresp_q <= r_ok ? RESP_OKAY : RESP_DECERR;
                        r_state <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (bus.rready) begin
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state <= W_IDLE;
            w_idx   <= '0;
            w_ok    <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                w_idx <= addr_idx(bus.awaddr);
                w_ok  <= addr_ok(bus.awaddr);
            end
            if (w_hs) begin
                w_data <= bus.wdata;
                w_strb <= bus.wstrb;
            end
            case (w_state)
                W_IDLE: begin
                    if (aw_hs && w_hs) begin
                        w_state <= W_COMMIT;
                    end else if (aw_hs) begin
                        w_state <= W_DATA;
                    end else if (w_hs) begin
                        w_state <= W_ADDR;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        w_state <= W_COMMIT;
                    end
                end
                W_ADDR: begin
                    if (aw_hs) begin
                        w_state <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    bresp_q <= w_ok ? RESP_OKAY : RESP_DECERR;
                    w_state <= W_RESP;
                end
                W_RESP: begin
                    if (bus.bready) begin
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    sram_bank #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_sram (
        .clk     (clk),
        .rd_en   (rd_sample),
        .rd_addr (rd_addr),
        .rd_data (sram_q),
        .wr_en   (sram_we),
        .wr_addr (w_idx),
        .wr_strb (w_strb),
        .wr_data (w_data)
    );

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// tb/tb_axi_lite_sram_slave.sv - directed self-checking bench for axi_lite_sram_slave
module tb_axi_lite_sram_slave;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    axi_lite_sram_slave_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    axi_lite_sram_slave #(
        .ADDR_W (32),
        .DATA_W (64),
        .DEPTH  (4096),
        .BASE   (32'h8000_0000),
        .RD_LAT (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_wait_b(output int lat, output logic [1:0] resp);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.bvalid && lat < 50);
        if (!bus.bvalid) begin
            n_cmp++; n_bad++;
            $display("FAIL bvalid_timeout: bvalid=%0b after %0d cycles, required 1", bus.bvalid, lat);
        end
        resp = bus.bresp;
    endtask

    task automatic write_finish();
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic write_issue(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                               output int lat, output logic [1:0] resp);
        int t;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!(bus.awready && bus.wready) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL write_accept_timeout: awready=%0b wready=%0b, required 1/1", bus.awready, bus.wready);
        end
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        write_wait_b(lat, resp);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            output int lat, output logic [1:0] resp);
        write_issue(a, d, s, lat, resp);
        write_finish();
    endtask

    task automatic read_issue(input logic [31:0] a, output int lat);
        int t;
        bus.araddr = a; bus.arvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bus.arready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL read_accept_timeout: arready=%0b, required 1", bus.arready);
        end
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rvalid && lat < 50);
        if (!bus.rvalid) begin
            n_cmp++; n_bad++;
            $display("FAIL rvalid_timeout: rvalid=%0b after %0d cycles, required 1", bus.rvalid, lat);
        end
    endtask

    task automatic read_finish();
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output int lat, output logic [63:0] d, output logic [1:0] resp);
        read_issue(a, lat);
        d = bus.rdata;
        resp = bus.rresp;
        read_finish();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 1'b0; bus.bready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.arready !== 1'b0) begin n_bad++; $display("FAIL reset_arready: got %0b want 0", bus.arready); end
        n_cmp++; if (bus.awready !== 1'b0) begin n_bad++; $display("FAIL reset_awready: got %0b want 0", bus.awready); end
        n_cmp++; if (bus.wready !== 1'b0) begin n_bad++; $display("FAIL reset_wready: got %0b want 0", bus.wready); end
        n_cmp++; if (bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %0b want 0", bus.rvalid); end
        n_cmp++; if (bus.bvalid !== 1'b0) begin n_bad++; $display("FAIL reset_bvalid: got %0b want 0", bus.bvalid); end
        n_cmp++; if (bus.rdata !== 64'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
        n_cmp++; if (bus.rresp !== 2'b00) begin n_bad++; $display("FAIL reset_rresp: got %b want 00", bus.rresp); end
        n_cmp++; if (bus.bresp !== 2'b00) begin n_bad++; $display("FAIL reset_bresp: got %b want 00", bus.bresp); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.arready !== 1'b1) begin n_bad++; $display("FAIL idle_arready: got %0b want 1", bus.arready); end
        n_cmp++; if ({bus.awready, bus.wready} !== 2'b11) begin n_bad++; $display("FAIL idle_aw_w_ready: got %b want 11", {bus.awready, bus.wready}); end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int lat; logic [1:0] resp; logic [63:0] d;
        do_write(32'h8000_0010, 64'h1122334455667788, 8'hFF, lat, resp);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wr_b_latency: got %0d want 2", lat); end
        n_cmp++; if (resp !== 2'b00) begin n_bad++; $display("FAIL wr_bresp: got %b want 00", resp); end
        do_read(32'h8000_0010, lat, d, resp);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
        n_cmp++; if (d !== 64'h1122334455667788) begin n_bad++; $display("FAIL rd_data: got %h want 1122334455667788", d); end
        n_cmp++; if (resp !== 2'b00) begin n_bad++; $display("FAIL rd_rresp: got %b want 00", resp); end
    endtask

    task automatic test_byte_mask();
        int lat; logic [1:0] resp; logic [63:0] d;
        do_write(32'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, lat, resp);
        do_read(32'h8000_0010, lat, d, resp);
        n_cmp++; if (d !== 64'h11223344FFFFFFFF) begin n_bad++; $display("FAIL mask_data: got %h want 11223344ffffffff", d); end
        do_write(32'h8000_0014, 64'h0, 8'h00, lat, resp);
        n_cmp++; if (resp !== 2'b00) begin n_bad++; $display("FAIL zero_strb_bresp: got %b want 00", resp); end
        do_read(32'h8000_0010, lat, d, resp);
        n_cmp++; if (d !== 64'h11223344FFFFFFFF) begin n_bad++; $display("FAIL zero_strb_data: got %h want 11223344ffffffff", d); end
    endtask

    task automatic test_split_write();
        int lat; logic [1:0] resp; logic [63:0] d; int nb;
        bus.awaddr = 32'h8000_0020; bus.awvalid = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.awready !== 1'b1) begin n_bad++; $display("FAIL split_aw_accept: got %0b want 1", bus.awready); end
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) begin
                bus.wdata = 64'h0123_4567_89AB_CDEF; bus.wstrb = 8'hFF; bus.wvalid = 1'b1;
            end
            @(negedge clk);
            n_cmp++; if (bus.awready !== 1'b0) begin n_bad++; $display("FAIL split_awready_c%0d: got %0b want 0", k, bus.awready); end
            n_cmp++; if (bus.wready !== 1'b1) begin n_bad++; $display("FAIL split_wready_c%0d: got %0b want 1", k, bus.wready); end
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b0;
        write_wait_b(lat, resp);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL split_b_latency: got %0d want 2", lat); end
        write_finish();
        nb = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.bvalid) nb++;
        end
        n_cmp++; if (nb !== 0) begin n_bad++; $display("FAIL split_extra_bvalid: got %0d want 0", nb); end
        @(posedge clk); #1;
        do_read(32'h8000_0020, lat, d, resp);
        n_cmp++; if (d !== 64'h0123_4567_89AB_CDEF) begin n_bad++; $display("FAIL split_aw_first_data: got %h want 0123456789abcdef", d); end

        bus.wdata = 64'hFEDC_BA98_7654_3210; bus.wstrb = 8'hFF; bus.wvalid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) begin
                bus.awaddr = 32'h8000_0028; bus.awvalid = 1'b1;
            end
            @(negedge clk);
            n_cmp++; if (bus.wready !== 1'b0) begin n_bad++; $display("FAIL split_wready_wf_c%0d: got %0b want 0", k, bus.wready); end
            n_cmp++; if (bus.awready !== 1'b1) begin n_bad++; $display("FAIL split_awready_wf_c%0d: got %0b want 1", k, bus.awready); end
            @(posedge clk); #1;
        end
        bus.awvalid = 1'b0;
        write_wait_b(lat, resp);
        write_finish();
        n_cmp++; if (resp !== 2'b00) begin n_bad++; $display("FAIL split_w_first_bresp: got %b want 00", resp); end
        do_read(32'h8000_0028, lat, d, resp);
        n_cmp++; if (d !== 64'hFEDC_BA98_7654_3210) begin n_bad++; $display("FAIL split_w_first_data: got %h want fedcba9876543210", d); end
    endtask

    task automatic test_backpressure();
        int lat; logic [1:0] resp; logic [63:0] d;
        read_issue(32'h8000_0020, lat);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_cmp++; if (bus.rvalid !== 1'b1) begin n_bad++; $display("FAIL bp_rvalid_c%0d: got %0b want 1", k, bus.rvalid); end
            n_cmp++; if (bus.rdata !== 64'h0123_4567_89AB_CDEF) begin n_bad++; $display("FAIL bp_rdata_c%0d: got %h want 0123456789abcdef", k, bus.rdata); end
            n_cmp++; if (bus.rresp !== 2'b00) begin n_bad++; $display("FAIL bp_rresp_c%0d: got %b want 00", k, bus.rresp); end
            n_cmp++; if (bus.arready !== 1'b0) begin n_bad++; $display("FAIL bp_arready_c%0d: got %0b want 0", k, bus.arready); end
        end
        read_finish();

        write_issue(32'h8000_0020, 64'h0123_4567_89AB_CDEF, 8'hFF, lat, resp);
        @(posedge clk); #1;
        bus.awaddr = 32'h8000_0010; bus.wdata = 64'h0; bus.wstrb = 8'hFF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++; if (bus.bvalid !== 1'b1) begin n_bad++; $display("FAIL bp_bvalid_c%0d: got %0b want 1", k, bus.bvalid); end
            n_cmp++; if ({bus.awready, bus.wready} !== 2'b00) begin n_bad++; $display("FAIL bp_aw_w_ready_c%0d: got %b want 00", k, {bus.awready, bus.wready}); end
            @(posedge clk); #1;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        write_finish();
        do_read(32'h8000_0010, lat, d, resp);
        n_cmp++; if (d !== 64'h11223344FFFFFFFF) begin n_bad++; $display("FAIL bp_stalled_write_leak: got %h want 11223344ffffffff", d); end
    endtask

    task automatic test_out_of_range();
        int lat; logic [1:0] resp; logic [63:0] d;
        do_read(32'h7FFF_FFF8, lat, d, resp);
        n_cmp++; if (resp !== 2'b11) begin n_bad++; $display("FAIL oor_rd_rresp: got %b want 11", resp); end
        n_cmp++; if (d !== 64'h0) begin n_bad++; $display("FAIL oor_rd_rdata: got %h want 0", d); end
        do_write(32'h8000_7FF8, 64'hCAFE_BABE_DEAD_BEEF, 8'hFF, lat, resp);
        n_cmp++; if (resp !== 2'b00) begin n_bad++; $display("FAIL last_word_bresp: got %b want 00", resp); end
        do_write(32'h8000_8000, 64'h0, 8'hFF, lat, resp);
        n_cmp++; if (resp !== 2'b11) begin n_bad++; $display("FAIL oor_wr_bresp: got %b want 11", resp); end
        do_read(32'h8000_7FF8, lat, d, resp);
        n_cmp++; if (d !== 64'hCAFE_BABE_DEAD_BEEF) begin n_bad++; $display("FAIL oor_wr_last_word: got %h want cafebabedeadbeef", d); end
        n_cmp++; if (resp !== 2'b00) begin n_bad++; $display("FAIL last_word_rresp: got %b want 00", resp); end
    endtask

    task automatic test_reset_abort();
        int lat; logic [1:0] resp; logic [63:0] d; int stale;
        bus.araddr = 32'h8000_0010; bus.arvalid = 1'b1;
        bus.awaddr = 32'h8000_0010; bus.awvalid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.arvalid = 1'b0; bus.awvalid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({bus.arready, bus.rvalid, bus.awready, bus.wready, bus.bvalid} !== 5'b0) begin
            n_bad++;
            $display("FAIL abort_all_low: got %b want 00000", {bus.arready, bus.rvalid, bus.awready, bus.wready, bus.bvalid});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({bus.arready, bus.awready, bus.wready} !== 3'b111) begin n_bad++; $display("FAIL abort_idle_ready: got %b want 111", {bus.arready, bus.awready, bus.wready}); end
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rvalid || bus.bvalid) stale++;
        end
        n_cmp++; if (stale !== 0) begin n_bad++; $display("FAIL abort_stale_valid: got %0d cycles want 0", stale); end
        @(posedge clk); #1;
        bus.wdata = 64'h0; bus.wstrb = 8'hFF;
        do_read(32'h8000_0010, lat, d, resp);
        n_cmp++; if (d !== 64'h11223344FFFFFFFF) begin n_bad++; $display("FAIL abort_no_commit: got %h want 11223344ffffffff", d); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_write_read();
        test_byte_mask();
        test_split_write();
        test_backpressure();
        test_out_of_range();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
